// File: rtl/isqrt_pipe_if.sv
// Argument/result bus between the formula FSMs and the square-root pipeline.
// No ready signal: every x_vld=1 cycle is an accepted argument.
interface isqrt_pipe_if;
    logic        x_vld;
    logic [31:0] x;
    logic        y_vld;
    logic [15:0] y;

    modport master (output x_vld, output x, input y_vld, input y);
    modport slave  (input x_vld, input x, output y_vld, output y);
endinterface

// File: rtl/isqrt_pipe.sv
// Fully pipelined 32-bit floor(sqrt(x)), restoring digit-by-digit, latency n_pipe_stages.
// ISQRT_PIPE_DATA_GATE_EN: data regs load only on valid and reset to 0, so y holds the last result.
module isqrt_pipe_stage #(
    parameter int ITERS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld_in,
    input  logic [31:0] rad_in,
    input  logic [17:0] rem_in,
    input  logic [15:0] root_in,
    output logic        vld_q,
    output logic [31:0] rad_q,
    output logic [17:0] rem_q,
    output logic [15:0] root_q
);
    logic [31:0] rad_c;
    logic [17:0] rem_c;
    logic [15:0] root_c;
    logic [17:0] rem_sh;
    logic [18:0] trial;

    // rem <= 2*root holds between iterations, so rem[17:16] is zero whenever it is shifted.
    always_comb begin
        rad_c  = rad_in;
        rem_c  = rem_in;
        root_c = root_in;
        rem_sh = '0;
        trial  = '0;
        for (int k = 0; k < ITERS; k++) begin
            rem_sh = {rem_c[15:0], rad_c[31:30]};
            trial  = {1'b0, rem_sh} - {1'b0, root_c, 2'b01};
            if (!trial[18]) begin
                rem_c  = trial[17:0];
                root_c = {root_c[14:0], 1'b1};
            end else begin
                rem_c  = rem_sh;
                root_c = {root_c[14:0], 1'b0};
            end
            rad_c = {rad_c[29:0], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) vld_q <= 1'b0;
        else     vld_q <= vld_in;
    end

`ifdef ISQRT_PIPE_DATA_GATE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
        end else if (vld_in) begin
            rad_q  <= rad_c;
            rem_q  <= rem_c;
            root_q <= root_c;
        end
    end
`else
    always_ff @(posedge clk) begin
        rad_q  <= rad_c;
        rem_q  <= rem_c;
        root_q <= root_c;
    end
`endif
endmodule

module isqrt_pipe #(
    parameter int n_pipe_stages = 4
) (
    input logic         clk,
    input logic         rst,
    isqrt_pipe_if.slave bus
);
    localparam int N     = n_pipe_stages;
    localparam int ITERS = 16 / ((N > 0) ? N : 1);

    if (!(N == 1 || N == 2 || N == 4 || N == 8 || N == 16)) begin : g_bad_depth
        $error("isqrt_pipe: n_pipe_stages must be 1, 2, 4, 8 or 16");
    end

    logic [N:0]       vld_pipe;
    logic [N:0][31:0] rad_p;
    logic [N:0][17:0] rem_p;
    logic [N:0][15:0] root_p;

    assign vld_pipe[0] = bus.x_vld;
    assign rad_p[0]    = bus.x;
    assign rem_p[0]    = '0;
    assign root_p[0]   = '0;

    for (genvar g = 0; g < N; g++) begin : g_stage
        isqrt_pipe_stage #(.ITERS(ITERS)) u_stage (
            .clk    (clk),
            .rst    (rst),
            .vld_in (vld_pipe[g]),
            .rad_in (rad_p[g]),
            .rem_in (rem_p[g]),
            .root_in(root_p[g]),
            .vld_q  (vld_pipe[g+1]),
            .rad_q  (rad_p[g+1]),
            .rem_q  (rem_p[g+1]),
            .root_q (root_p[g+1])
        );
    end

    assign bus.y_vld = vld_pipe[N];
    assign bus.y     = root_p[N];

    // Final remainder and exhausted radicand are not part of the result.
    logic unused_tail;
    assign unused_tail = ^{rad_p[N], rem_p[N]};
endmodule
